// File: rtl/header_stream_pkg.sv
// Shared types, default dimensions and the residual width helper for the
// streaming block-header path.
package header_stream_pkg;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CH_W      = 8;
  localparam int DEF_MAX_RES_W = 4;
  localparam int DEF_WID_W     = $clog2(DEF_CH_W + 2);

  // ACCUM: beats flow freely. HOLD: a result is parked and has been refused.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } hs_state_e;

  // Minimal two's-complement width of a CH_W+1-bit signed residual (1..CH_W+1).
  // Negative values are folded with ~r so both signs share one leading-one scan.
  function automatic logic [DEF_WID_W-1:0] res_width(input logic signed [DEF_CH_W:0] r);
    logic [DEF_CH_W-1:0] mag;
    logic [DEF_WID_W-1:0] w;
    mag = r[DEF_CH_W] ? ~r[DEF_CH_W-1:0] : r[DEF_CH_W-1:0];
    w   = DEF_WID_W'(1);
    for (int i = 0; i < DEF_CH_W; i++) begin
      if (mag[i]) w = DEF_WID_W'(i + 2);
    end
    return w;
  endfunction

endpackage

// File: rtl/header_stream_res_width_max.sv
// Largest residual width among the pixels of one channel within a beat.
module res_width_max
  import header_stream_pkg::*;
#(
  parameter int BEAT_PIX = 8,
  parameter int CH_W     = DEF_CH_W,
  parameter int WID_W    = DEF_WID_W
) (
  input  logic [BEAT_PIX-1:0][CH_W:0] res,
  output logic [WID_W-1:0]            max_w
);

  // Reduce per-pixel widths to the beat maximum.
  always_comb begin
    logic [WID_W-1:0] w;
    max_w = '0;
    w     = '0;
    for (int p = 0; p < BEAT_PIX; p++) begin
      w = res_width(res[p]);
      if (w > max_w) max_w = w;
    end
  end

endmodule

// File: rtl/header_stream.sv
// Streaming block-header generator: accumulates per-channel base and worst
// residual width over a multi-beat block, then presents one registered header
// plus a compressable flag through a valid/ready output slot.
module header_stream
  import header_stream_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = DEF_CH_W,
  parameter int BEAT_PIX  = 8,
  parameter int BLOCK_PIX = 32,
  parameter int MAX_RES_W = DEF_MAX_RES_W,
  localparam int BEATS    = BLOCK_PIX / BEAT_PIX,
  localparam int WID_W    = $clog2(CH_W + 2),
  localparam int HDR_W    = NUM_CH * (CH_W + WID_W)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BEAT_PIX-1:0][NUM_CH-1:0][CH_W-1:0] in_pixels,
  input  logic                                     force_raw,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     compressable,
  output logic [HDR_W-1:0]                         h,
  output logic [15:0]                              comp_count
);

  localparam int FLD_W = CH_W + WID_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
  hs_state_e                          state_q, state_d;
  logic                               out_valid_q, out_valid_d;
  logic                               compressable_q, compressable_d;
  logic [HDR_W-1:0]                   h_q, h_d;
  logic [15:0]                        comp_count_q, comp_count_d;
  logic [NUM_CH-1:0][CH_W-1:0]        base_q, base_d, base_eff;
  logic [NUM_CH-1:0][WID_W-1:0]       max_w_q, max_w_d, beat_max, max_upd;
  logic                               raw_q, raw_d, raw_eff;
  logic [NUM_CH-1:0][BEAT_PIX-1:0][CH_W:0] res;
  logic                               first_beat, last_beat, accept, fits;

  // Beat position, input handshake. Only the final beat can stall, and only
  // while an earlier result is still waiting in the output slot.
  always_comb begin
    first_beat = (beat_cnt_q == '0);
    last_beat  = (beat_cnt_q == LAST_BEAT);
    in_ready   = !(last_beat && !out_ready && (out_valid_q || state_q == HOLD));
    accept     = in_valid && in_ready;
  end

  // Residuals; on beat 0 the base comes straight from the incoming pixel 0.
  always_comb begin
    base_eff = base_q;
    raw_eff  = raw_q;
    res      = '0;
    if (first_beat) raw_eff = force_raw;
    for (int c = 0; c < NUM_CH; c++) begin
      if (first_beat) base_eff[c] = in_pixels[0][c];
      for (int p = 0; p < BEAT_PIX; p++) begin
        res[c][p] = {1'b0, in_pixels[p][c]} - {1'b0, base_eff[c]};
      end
    end
  end

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    res_width_max #(
      .BEAT_PIX (BEAT_PIX),
      .CH_W     (CH_W),
      .WID_W    (WID_W)
    ) u_rwm (
      .res   (res[gc]),
      .max_w (beat_max[gc])
    );
  end

  // Running worst width per channel and the block-level fit test.
  always_comb begin
    max_upd = beat_max;
    fits    = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!first_beat && max_w_q[c] > beat_max[c]) max_upd[c] = max_w_q[c];
      if (int'(max_upd[c]) > MAX_RES_W) fits = 1'b0;
    end
  end

  // Next-state for counters, accumulators, result slot and FSM.
  always_comb begin
    beat_cnt_d     = beat_cnt_q;
    base_d         = base_q;
    max_w_d        = max_w_q;
    raw_d          = raw_q;
    h_d            = h_q;
    compressable_d = compressable_q;
    out_valid_d    = out_valid_q;
    comp_count_d   = comp_count_q + 16'(out_valid_q && out_ready && compressable_q);
    state_d        = (out_valid_q && !out_ready) ? HOLD : ACCUM;
    if (accept) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
      max_w_d    = max_upd;
      if (first_beat) begin
        base_d = base_eff;
        raw_d  = force_raw;
      end
    end
    if (accept && last_beat) begin
      for (int c = 0; c < NUM_CH; c++) begin
        h_d[c*FLD_W +: FLD_W] = {base_eff[c], max_upd[c]};
      end
      compressable_d = !raw_eff && fits;
      out_valid_d    = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q     <= '0;
      state_q        <= ACCUM;
      out_valid_q    <= 1'b0;
      compressable_q <= 1'b0;
      h_q            <= '0;
      comp_count_q   <= '0;
    end else begin
      beat_cnt_q     <= beat_cnt_d;
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      compressable_q <= compressable_d;
      h_q            <= h_d;
      comp_count_q   <= comp_count_d;
    end
  end

  // Block accumulators; always rewritten on beat 0, so no reset is needed.
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    max_w_q <= max_w_d;
    raw_q   <= raw_d;
  end

  assign out_valid    = out_valid_q;
  assign compressable = compressable_q;
  assign h            = h_q;
  assign comp_count   = comp_count_q;

endmodule

// File: tb/tb_header_stream.sv
// Testbench for header_stream: directed scenarios with literal expectations
// plus randomized traffic against a block-level behavioural model.
module tb_header_stream;

  localparam int NUM_CH    = 4;
  localparam int CH_W      = 8;
  localparam int BEAT_PIX  = 8;
  localparam int BLOCK_PIX = 32;
  localparam int MAX_RES_W = 4;
  localparam int BEATS     = BLOCK_PIX / BEAT_PIX;
  localparam int HDR_W     = 48;

  typedef logic [BEAT_PIX-1:0][NUM_CH-1:0][CH_W-1:0] beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  beat_t            in_pixels = '0;
  logic             force_raw = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             compressable;
  logic [HDR_W-1:0] h;
  logic [15:0]      comp_count;

  always #5 clk = ~clk;

  header_stream dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixels    (in_pixels),
    .force_raw    (force_raw),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .compressable (compressable),
    .h            (h),
    .comp_count   (comp_count)
  );

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;
  bit  b2b_on = 1'b0;
  bit  rnd_on = 1'b0;
  time v_times[$];
  beat_t stim [BEATS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_beat;
  bit          m_valid;
  logic [47:0] m_h;
  bit          m_comp;
  int          m_cnt;
  bit          m_raw;
  int          m_pix [BLOCK_PIX][NUM_CH];

  function automatic int minw(input int r);
    for (int w = 1; w <= CH_W + 1; w++)
      if (r >= -(1 << (w - 1)) && r < (1 << (w - 1))) return w;
    return 99;
  endfunction

  function automatic void finish_block();
    bit comp;
    comp = !m_raw;
    for (int c = 0; c < NUM_CH; c++) begin
      int base, w;
      base = m_pix[0][c];
      w = 0;
      for (int p = 0; p < BLOCK_PIX; p++)
        if (minw(m_pix[p][c] - base) > w) w = minw(m_pix[p][c] - base);
      if (w > MAX_RES_W) comp = 1'b0;
      m_h[c*12 +: 12] = {8'(base), 4'(w)};
    end
    m_comp  = comp;
    m_valid = 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_beat = 0; m_valid = 1'b0; m_h = '0; m_comp = 1'b0; m_cnt = 0;
    end else begin
      bit rdy;
      rdy = !(m_beat == BEATS - 1 && m_valid && !out_ready);
      if (m_valid && out_ready) begin
        if (m_comp) m_cnt = (m_cnt + 1) % 65536;
        m_valid = 1'b0;
      end
      if (in_valid && rdy) begin
        for (int p = 0; p < BEAT_PIX; p++)
          for (int c = 0; c < NUM_CH; c++)
            m_pix[m_beat*BEAT_PIX + p][c] = int'(in_pixels[p][c]);
        if (m_beat == 0) m_raw = force_raw;
        if (m_beat == BEATS - 1) finish_block();
        m_beat = (m_beat + 1) % BEATS;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("compressable", 64'(compressable), 64'(m_comp));
      chk("h", 64'(h), 64'(m_h));
      chk("comp_count", 64'(comp_count), 64'(m_cnt[15:0]));
      chk("in_ready", 64'(in_ready), 64'(!(m_beat == BEATS - 1 && m_valid && !out_ready)));
      if (b2b_on && out_valid) v_times.push_back($time);
    end
  end

  // Random output backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic realign();
    @(posedge clk); #2;
  endtask

  task automatic fill_uniform(input logic [7:0] v);
    for (int b = 0; b < BEATS; b++) stim[b] = {(BEAT_PIX*NUM_CH){v}};
  endtask

  task automatic send_beat(input beat_t px, input logic fr);
    bit ok, acc;
    in_pixels = px;
    force_raw = fr;
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #2;
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid  = 1'b0;
    force_raw = 1'b0;
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_block(input logic fr);
    for (int b = 0; b < BEATS; b++) send_beat(stim[b], (b == 0) ? fr : 1'b0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_h", 64'(h), 64'(0));
    chk("rst_comp_count", 64'(comp_count), 64'(0));
    realign();
    rst = 1'b1;
    out_ready = 1'b1;

    // Uniform block
    fill_uniform(8'h40);
    send_block(1'b0);
    @(negedge clk);
    chk("uniform_h", 64'(h), 64'h401401401401);
    chk("uniform_comp", 64'(compressable), 64'(1));
    chk("uniform_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    chk("uniform_count", 64'(comp_count), 64'(1));
    realign();

    // Width boundary: r=-8, r=+8, r=+255
    fill_uniform(8'h40);
    stim[2][5][2] = 8'h38;
    send_block(1'b0);
    @(negedge clk);
    chk("neg8_h", 64'(h), 64'h401404401401);
    chk("neg8_comp", 64'(compressable), 64'(1));
    realign();
    stim[2][5][2] = 8'h48;
    send_block(1'b0);
    @(negedge clk);
    chk("pos8_h", 64'(h), 64'h401405401401);
    chk("pos8_comp", 64'(compressable), 64'(0));
    realign();
    fill_uniform(8'h00);
    stim[3][7][0] = 8'hFF;
    send_block(1'b0);
    @(negedge clk);
    chk("pos255_h", 64'(h), 64'h001001001009);
    chk("pos255_comp", 64'(compressable), 64'(0));
    realign();

    // force_raw on beat 0 only
    fill_uniform(8'h40);
    send_block(1'b1);
    @(negedge clk);
    chk("raw_h", 64'(h), 64'h401401401401);
    chk("raw_comp", 64'(compressable), 64'(0));
    @(negedge clk);
    chk("raw_count", 64'(comp_count), 64'(2));
    realign();

    // Backpressure: A parked, B's final beat stalls until out_ready
    out_ready = 1'b0;
    fill_uniform(8'h40);
    send_block(1'b0);
    fill_uniform(8'h20);
    for (int b = 0; b < BEATS - 1; b++) send_beat(stim[b], 1'b0);
    in_pixels = stim[BEATS-1];
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_h", 64'(h), 64'h401401401401);
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    realign();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    realign();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_b_h", 64'(h), 64'h201201201201);
    chk("bp_b_valid", 64'(out_valid), 64'(1));
    chk("bp_a_count", 64'(comp_count), 64'(3));
    @(negedge clk);
    chk("bp_b_count", 64'(comp_count), 64'(4));
    realign();

    // Back-to-back: three blocks, continuous beats
    v_times.delete();
    b2b_on = 1'b1;
    fill_uniform(8'h10);
    send_block(1'b0);
    fill_uniform(8'h90);
    stim[1][0][3] = 8'h00;
    send_block(1'b0);
    fill_uniform(8'h80);
    send_block(1'b0);
    @(negedge clk);
    @(negedge clk);
    b2b_on = 1'b0;
    chk("b2b_results", 64'(v_times.size()), 64'(3));
    if (v_times.size() >= 3) begin
      chk("b2b_spacing1", 64'(v_times[1] - v_times[0]), 64'(40));
      chk("b2b_spacing2", 64'(v_times[2] - v_times[1]), 64'(40));
    end
    chk("b2b_count", 64'(comp_count), 64'(6));
    realign();

    // Reset mid-block
    fill_uniform(8'h40);
    send_beat(stim[0], 1'b0);
    send_beat(stim[1], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_h", 64'(h), 64'(0));
    chk("midrst_count", 64'(comp_count), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    realign();
    rst = 1'b1;
    fill_uniform(8'h33);
    stim[1][0][1] = 8'h35;
    send_block(1'b0);
    @(negedge clk);
    chk("postrst_h", 64'(h), 64'h331331333331);
    chk("postrst_comp", 64'(compressable), 64'(1));
    realign();

    // Randomized traffic
    rnd_on = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int spread;
      logic [7:0] bases [NUM_CH];
      case ($urandom_range(0, 3))
        0: spread = 2;
        1: spread = 8;
        2: spread = 16;
        default: spread = 255;
      endcase
      for (int c = 0; c < NUM_CH; c++) bases[c] = 8'($urandom_range(0, 255));
      for (int b = 0; b < BEATS; b++)
        for (int p = 0; p < BEAT_PIX; p++)
          for (int c = 0; c < NUM_CH; c++)
            stim[b][p][c] = 8'(int'(bases[c]) + int'($urandom_range(0, 2*spread)) - spread);
      for (int b = 0; b < BEATS; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            in_valid  = 1'b0;
            in_pixels = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            force_raw = 1'($urandom_range(0, 1));
            realign();
          end
        end
        send_beat(stim[b], ($urandom_range(0, 4) == 0));
      end
    end
    rnd_on = 1'b0;
    realign();
    out_ready = 1'b1;
    repeat (4) realign();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
